data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Slave-side responder for the CPU data SRAM interface: services en/we/addr/wdata requests and returns rdata with fixed one-cycle latency.
- Backs a word-addressed RAM plus a small MMIO window:
  - free-running timer
  - scratch register
  - byte transmit FIFO drained by a valid/ready port
- Sits beside the CPU top in the SoC wrapper, directly on the data_sram_* nets.

Parameters:
- RAM_ADDR_W, 14, word-address width of the backing RAM (2^RAM_ADDR_W x 32-bit words).
- MMIO_BASE, 16'hbfaf, value of addr[31:16] that selects the MMIO window.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_sram_en  in  1  request valid this cycle.
- data_sram_we  in  4  byte write enables; 4'b0000 with en=1 is a read.
- data_sram_addr  in  32  byte address; addr[1:0] ignored.
- data_sram_wdata  in  32  write data, lane i = wdata[8i+7:8i].
- data_sram_rdata  out  32  read data, valid the cycle after a read request.
- tx_valid  out  1  FIFO non-empty.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts head when tx_valid=1.

Behaviour:
- Reset values:
  - data_sram_rdata=0, timer=0, scratch=0.
  - FIFO empty (tx_valid=0, tx_data=0), overflow=0.
  - RAM contents are not reset.
- Decode: mmio_sel = (addr[31:16]==MMIO_BASE).
  - RAM index = addr[RAM_ADDR_W+1:2]; higher bits are ignored (aliasing).
- Read (en=1, we=0) in cycle N: rdata presents the selected word from cycle N+1.
  - rdata holds that value until the next read is accepted.
  - Write cycles and idle cycles leave rdata unchanged.
- RAM write (en=1, we!=0): only enabled lanes are updated at the edge.
  - A read of the same word in cycle N+1 returns the merged new value (read-after-write correct).
- MMIO offsets (addr[7:2]):
  - 0x00 TIMER: increments by 1 every cycle and wraps 0xFFFFFFFF->0.
    - A write replaces enabled bytes, and the write wins over the increment that cycle.
    - Reads return the pre-edge value of cycle N.
  - 0x04 SCRATCH: plain R/W with byte enables.
  - 0x08 TXDATA: a write with we[0]=1 pushes wdata[7:0].
    - If the FIFO is full and no pop occurs that cycle, the push is dropped and overflow is set (sticky).
    - Reads return 0.
  - 0x0C STATUS: read = {16'b0, count[7:0] zero-extended, 5'b0, overflow, full, empty}.
    - A write with we[0]=1 and wdata[2]=1 clears overflow.
  - Any other offset: reads return 0, writes are ignored.
- FIFO:
  - Circular buffer with rd/wr pointers and count of width log2(FIFO_DEPTH)+1.
  - Pop when tx_valid & tx_ready; tx_data = head entry, combinational from storage.
  - Push and pop in the same cycle: both occur and count is unchanged.
    - When full, this push is accepted (no overflow).
    - When empty, only the push occurs and tx_valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow set and clear in the same cycle: set wins.
- Reset asserted mid-operation clears all registers immediately (async), including any in-flight rdata and queued bytes; the RAM array is retained.
- The CPU side has no backpressure: every en=1 cycle is accepted.

Test Plan:
- Write 0xdeadbeef to 0x1c000040 with we=4'b1111, then read it, then write we=4'b0010 wdata=0x00005500 and read again -> rdata=0xdeadbeef the cycle after the first read, then 0xdead55ef.
- Release reset, idle 10 cycles, read 0xbfaf0000 -> rdata=0x0000000a. Write 0xfffffffe, then read 2 cycles later -> 0xffffffff. Next read 2 cycles later -> 0x00000001 (wrap).
- Hold tx_ready=0 and push bytes 0x41..0x49 (9 pushes, depth 8), then read STATUS -> 0x00000806 (count=8, full, overflow). tx_data=0x41.
- Raise tx_ready for 8 cycles -> bytes 0x41..0x48 appear in order and tx_valid falls. Write STATUS wdata=0x4, then read STATUS -> 0x00000001.
- With the FIFO full, push 0x50 in the same cycle tx_ready=1 pops -> overflow stays 0, count stays 8, and 0x50 later emerges last.
- Assert reset while the FIFO holds 3 bytes and rdata=0x12345678 -> tx_valid=0 and rdata=0 immediately. A previously written RAM word still reads back intact after reset.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data SRAM slave: word-addressed RAM plus an MMIO window (timer, scratch, byte TX FIFO).
// Read data is registered, so it appears one cycle after the request and holds until the next read.
module data_sram_responder #(
  parameter int          RAM_ADDR_W = 14,
  parameter logic [15:0] MMIO_BASE  = 16'hbfaf,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [5:0] OFF_TIMER   = 6'd0;
  localparam logic [5:0] OFF_SCRATCH = 6'd1;
  localparam logic [5:0] OFF_TXDATA  = 6'd2;
  localparam logic [5:0] OFF_STATUS  = 6'd3;

  logic [31:0] ram [2**RAM_ADDR_W];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [31:0]      timer;
  logic [31:0]      scratch;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic                  mmio_sel;
  logic [5:0]            mmio_off;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  rd_req;
  logic                  wr_req;
  logic                  ram_wr;
  logic                  timer_wr;
  logic                  scratch_wr;
  logic                  push;
  logic                  push_ok;
  logic                  pop;
  logic                  ovf_set;
  logic                  ovf_clr;
  logic                  empty;
  logic                  full;
  logic [7:0]            count_ext;
  logic [31:0]           mmio_rdata;
  logic                  unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign mmio_sel         = (data_sram_addr[31:16] == MMIO_BASE);
  assign mmio_off         = data_sram_addr[7:2];
  assign ram_idx          = data_sram_addr[RAM_ADDR_W+1:2];
  assign unused_addr_bits = ^data_sram_addr[1:0];

  assign rd_req     = data_sram_en & (data_sram_we == 4'b0000);
  assign wr_req     = data_sram_en & (data_sram_we != 4'b0000);
  assign ram_wr     = wr_req & ~mmio_sel;
  assign timer_wr   = wr_req & mmio_sel & (mmio_off == OFF_TIMER);
  assign scratch_wr = wr_req & mmio_sel & (mmio_off == OFF_SCRATCH);
  assign push       = data_sram_en & data_sram_we[0] & mmio_sel & (mmio_off == OFF_TXDATA);
  assign ovf_clr    = data_sram_en & data_sram_we[0] & mmio_sel & (mmio_off == OFF_STATUS)
                    & data_sram_wdata[2];

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign pop       = tx_valid & tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;
  assign count_ext = 8'(count);

  assign tx_valid = ~empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_TIMER:   mmio_rdata = timer;
      OFF_SCRATCH: mmio_rdata = scratch;
      OFF_STATUS:  mmio_rdata = {16'h0000, count_ext, 5'b00000, overflow, full, empty};
      default:     mmio_rdata = '0;
    endcase
  end

  // Storage arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) ram[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= data_sram_wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sram_rdata <= '0;
    end else if (rd_req) begin
      data_sram_rdata <= mmio_sel ? mmio_rdata : ram[ram_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer   <= '0;
      scratch <= '0;
    end else begin
      timer <= timer_wr ? merge_bytes(timer, data_sram_wdata, data_sram_we) : timer + 32'd1;
      if (scratch_wr) scratch <= merge_bytes(scratch, data_sram_wdata, data_sram_we);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: constant vector table, directed timer/FIFO/reset sequences,
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_data_sram_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready = 1'b0;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;

  int vectors = 0;
  int miscompares = 0;

  localparam int DEPTH = 8;

  always #5 clk = ~clk;

  data_sram_responder #(.RAM_ADDR_W(14), .MMIO_BASE(16'hbfaf), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(ready)
  );

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_timer;
  logic [31:0] m_scratch;
  logic [31:0] m_rdata;
  logic        m_ovf;
  logic [7:0]  m_q [$];

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] exp_rdata;
    logic        exp_valid;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] l);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (l[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_timer = '0; m_scratch = '0; m_rdata = '0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_edge(input logic e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, input logic r);
    bit mm;
    int off;
    int idx;
    int pre_n;
    bit pop;
    bit push;
    bit clr;
    bit setov;
    mm = (a[31:16] == 16'hbfaf);
    off = int'(a[7:2]);
    idx = int'(a[15:2]);
    pre_n = m_q.size();
    pop = (pre_n > 0) && r;
    push = e && mm && off == 2 && w[0];
    clr = e && mm && off == 3 && w[0] && d[2];
    setov = 1'b0;
    if (e && w == 4'h0) begin
      if (!mm) m_rdata = m_ram.exists(idx) ? m_ram[idx] : 32'hxxxxxxxx;
      else if (off == 0) m_rdata = m_timer;
      else if (off == 1) m_rdata = m_scratch;
      else if (off == 3) m_rdata = {16'h0, 8'(pre_n), 5'b0, m_ovf, pre_n == DEPTH, pre_n == 0};
      else m_rdata = 32'h0;
    end
    if (e && w != 4'h0 && !mm)
      m_ram[idx] = merge(m_ram.exists(idx) ? m_ram[idx] : 32'hxxxxxxxx, d, w);
    if (e && w != 4'h0 && mm && off == 0) m_timer = merge(m_timer, d, w);
    else m_timer = m_timer + 32'd1;
    if (e && w != 4'h0 && mm && off == 1) m_scratch = merge(m_scratch, d, w);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (pre_n < DEPTH || pop) m_q.push_back(d[7:0]);
      else setov = 1'b1;
    end
    if (clr) m_ovf = 1'b0;
    if (setov) m_ovf = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, let the edge happen, update model, compare 1 time unit later.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic r);
    en = e; we = w; addr = a; wdata = d; ready = r;
    @(posedge clk);
    model_edge(e, w, a, d, r);
    #1;
    check("model rdata", rdata, m_rdata);
    check("model tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
    check("model tx_data", 32'(tx_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 4'h0, 32'h0, 32'h0, r);
  endtask

  function automatic logic [31:0] pool_addr(input int i);
    logic [13:0] idx;
    logic [15:0] hi;
    idx = 14'((i * 1021) & 16'h3fff);
    hi = 16'($urandom_range(0, 32'hbfae));
    return {hi, idx, 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 4'hf, 32'h1c000040, 32'hdeadbeef, 1'b0, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 4'h0, 32'h1c000040, 32'h00000000, 1'b0, 32'hdeadbeef, 1'b0};
    tbl[2]  = '{1'b1, 4'h2, 32'h1c000040, 32'h00005500, 1'b0, 32'hdeadbeef, 1'b0};
    tbl[3]  = '{1'b1, 4'h0, 32'h1c000040, 32'h00000000, 1'b0, 32'hdead55ef, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 32'hdead55ef, 1'b0};
    tbl[5]  = '{1'b1, 4'h5, 32'hbfaf0004, 32'ha5a5a5a5, 1'b0, 32'hdead55ef, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 32'hbfaf0004, 32'h00000000, 1'b0, 32'h00a500a5, 1'b0};
    tbl[7]  = '{1'b1, 4'h0, 32'hbfaf0008, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 32'h5c000040, 32'h00000000, 1'b0, 32'hdead55ef, 1'b0};
    tbl[9]  = '{1'b1, 4'hf, 32'hbfaf0010, 32'hffffffff, 1'b0, 32'hdead55ef, 1'b0};
    tbl[10] = '{1'b1, 4'h0, 32'hbfaf0010, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    tbl[11] = '{1'b1, 4'h0, 32'hbfaf000c, 32'h00000000, 1'b0, 32'h00000001, 1'b0};

    model_reset();
    #3;
    check("reset rdata", rdata, 32'h0);
    check("reset tx_valid", 32'(tx_valid), 32'h0);
    check("reset tx_data", 32'(tx_data), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdy);
      check($sformatf("tbl[%0d] rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("tbl[%0d] tx_valid", i), 32'(tx_valid), 32'(tbl[i].exp_valid));
    end

    // Timer: count from reset release, write-over-increment, wrap
    reset = 1'b1; model_reset();
    #10;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) idle(1'b0);
    step(1'b1, 4'h0, 32'hbfaf0000, 32'h0, 1'b0);
    check("timer after 10 idle", rdata, 32'h0000000a);
    step(1'b1, 4'hf, 32'hbfaf0000, 32'hfffffffe, 1'b0);
    idle(1'b0);
    step(1'b1, 4'h0, 32'hbfaf0000, 32'h0, 1'b0);
    check("timer max", rdata, 32'hffffffff);
    idle(1'b0);
    step(1'b1, 4'h0, 32'hbfaf0000, 32'h0, 1'b0);
    check("timer wrap", rdata, 32'h00000001);

    // FIFO overflow, drain order, overflow clear
    for (int k = 0; k < 9; k++) step(1'b1, 4'h1, 32'hbfaf0008, 32'(8'h41 + k), 1'b0);
    step(1'b1, 4'h0, 32'hbfaf000c, 32'h0, 1'b0);
    check("status full+ovf", rdata, 32'h00000806);
    check("head after overflow", 32'(tx_data), 32'h41);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain valid %0d", k), 32'(tx_valid), 32'h1);
      check($sformatf("drain byte %0d", k), 32'(tx_data), 32'(8'h41 + k));
      idle(1'b1);
    end
    check("drained valid", 32'(tx_valid), 32'h0);
    step(1'b1, 4'h1, 32'hbfaf000c, 32'h4, 1'b0);
    step(1'b1, 4'h0, 32'hbfaf000c, 32'h0, 1'b0);
    check("status after clear", rdata, 32'h00000001);

    // Push into a full FIFO while popping
    for (int k = 0; k < 8; k++) step(1'b1, 4'h1, 32'hbfaf0008, 32'(8'h60 + k), 1'b0);
    step(1'b1, 4'h1, 32'hbfaf0008, 32'h50, 1'b1);
    step(1'b1, 4'h0, 32'hbfaf000c, 32'h0, 1'b0);
    check("status full push+pop", rdata, 32'h00000802);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("pp byte %0d", k), 32'(tx_data), (k == 7) ? 32'h50 : 32'(8'h61 + k));
      idle(1'b1);
    end
    check("pp drained", 32'(tx_valid), 32'h0);

    // Async reset mid-operation keeps RAM
    for (int k = 0; k < 3; k++) step(1'b1, 4'h1, 32'hbfaf0008, 32'(8'h70 + k), 1'b0);
    step(1'b1, 4'hf, 32'h1c000100, 32'h12345678, 1'b0);
    step(1'b1, 4'h0, 32'h1c000100, 32'h0, 1'b0);
    check("pre-reset rdata", rdata, 32'h12345678);
    check("pre-reset valid", 32'(tx_valid), 32'h1);
    #2;
    reset = 1'b1; model_reset();
    #1;
    check("async reset rdata", rdata, 32'h0);
    check("async reset valid", 32'(tx_valid), 32'h0);
    check("async reset data", 32'(tx_data), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 4'h0, 32'h1c000100, 32'h0, 1'b0);
    check("ram kept 1", rdata, 32'h12345678);
    step(1'b1, 4'h0, 32'h1c000040, 32'h0, 1'b0);
    check("ram kept 2", rdata, 32'hdead55ef);

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) step(1'b1, 4'hf, pool_addr(i), $urandom, 1'($urandom_range(0, 1)));
    for (int n = 0; n < 2000; n++) begin
      int op;
      int sel;
      int lvl;
      logic [3:0] w;
      logic [31:0] a;
      lvl = ((n / 200) % 2 == 0) ? 1 : 10;
      op = $urandom_range(0, 9);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (op < 4) begin
        a = pool_addr($urandom_range(0, 15));
      end else begin
        sel = $urandom_range(0, 9);
        a = {16'hbfaf, 8'($urandom), (sel < 4) ? 6'd2 : 6'(sel - 4), 2'($urandom_range(0, 3))};
        if (sel < 4 && w != 4'h0) w[0] = 1'b1;
      end
      step(1'($urandom_range(0, 7) != 0), w, a, $urandom, 1'($urandom_range(0, 15) < lvl));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
